axis_uart_arbiter: RTL
======================

AXIS_UART_ARBITER -- requirements
Module: axis_uart_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 2, SHALL set the number of AXI-stream source ports (legal 2..4).
REQ-002 Parameter DATA_BITS, default 8, SHALL set the byte width of every stream.
REQ-003 Parameter TIMEOUT, default 255, SHALL set the number of idle granted cycles before a forced release (legal 1..65535).
REQ-004 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 s_axis_data  input  NUM_SRC*DATA_BITS  source data; source i occupies bits [i*DATA_BITS +: DATA_BITS].
REQ-007 s_axis_valid  input  NUM_SRC  per-source valid.
REQ-008 s_axis_last  input  NUM_SRC  per-source end-of-packet marker.
REQ-009 s_axis_ready  output  NUM_SRC  per-source ready; at most one bit high in any cycle.
REQ-010 m_axis_data  output  DATA_BITS  data toward the UART transmitter.
REQ-011 m_axis_valid  output  1  valid toward the UART transmitter.
REQ-012 m_axis_last  output  1  end-of-packet toward the UART transmitter.
REQ-013 m_axis_ready  input  1  UART transmitter ready (high when the TX shifter accepts a byte).
REQ-014 grant_id  output  clog2(NUM_SRC)  index of the currently granted source; holds the last grant when idle.
REQ-015 busy  output  1  high while a packet is locked to a source.
REQ-016 timeout_pulse  output  1  one-cycle pulse on a forced release.

Function
REQ-017 The FSM SHALL have two states: IDLE and LOCK.
REQ-018 In IDLE, if any s_axis_valid is high, the block SHALL select a winner round-robin, searching upward (with wrap-around) from (last grant + 1) mod NUM_SRC, register it into grant_id, and enter LOCK on the next edge.
REQ-019 In IDLE, m_axis_valid and all s_axis_ready bits SHALL be 0, so no transfer occurs during the arbitration cycle.
REQ-020 In LOCK, the path SHALL be combinational and zero-latency: m_axis_data/valid/last equal the granted source's signals, s_axis_ready[grant_id] equals m_axis_ready, and all other ready bits are 0.
REQ-021 A beat SHALL transfer only when m_axis_valid and m_axis_ready are both high.
REQ-022 A transferred beat with m_axis_last=1 SHALL return the FSM to IDLE on that edge; re-arbitration then starts from grant_id+1.
REQ-023 The grant SHALL NOT change mid-packet, regardless of the valid activity of other sources.
REQ-024 In LOCK, a 16-bit idle counter SHALL increment each cycle the granted s_axis_valid is low, and clear on any transfer and on entry to LOCK.
REQ-025 When the idle counter equals TIMEOUT, the FSM SHALL go to IDLE on the next edge and assert timeout_pulse for exactly that cycle; no synthetic last beat is emitted.
REQ-026 Back-pressure (valid high, ready low) SHALL NOT advance the idle counter.
REQ-027 A single-beat packet (last on the first beat) SHALL be legal and SHALL take 2 cycles minimum: 1 arbitration cycle and 1 transfer cycle.
REQ-028 busy SHALL equal (state == LOCK).

Reset
REQ-029 On rst high, the block SHALL enter IDLE immediately, with grant_id = NUM_SRC-1 (so source 0 wins first), idle counter = 0, timeout_pulse = 0, busy = 0, m_axis_valid = 0, and s_axis_ready = 0.
REQ-030 A reset asserted mid-packet SHALL abort the packet with no further beats; the sources are responsible for restarting the packet.

Structure
REQ-031 The state encoding and the idle-counter width SHALL be defined in a shared package, axis_uart_pkg.
REQ-032 The round-robin priority search SHALL be a sub-module, rr_pick (inputs: request vector and pointer; output: winner index and found flag), which is purely combinational.

Verification
REQ-033 Reset, then source 0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43) with m_axis_ready=1 -> bytes appear in order on m_axis; busy high for 3 cycles; grant_id=0.
REQ-034 Sources 0 and 1 both hold valid in the same cycle, each sending 2-byte packets -> packets are granted 0,1,0,1 with no interleaving of bytes within a packet.
REQ-035 Source 1 is granted, sends 1 byte without last, then drops valid -> timeout_pulse fires once after 255 idle cycles, busy falls, and source 0 (pending) is granted next.
REQ-036 m_axis_ready is held low for 10 cycles mid-packet with source valid high -> no timeout, data stable, packet completes once ready returns.
REQ-037 rst asserted asynchronously during the second byte of a 4-byte packet -> m_axis_valid and all ready bits drop immediately, and grant_id = NUM_SRC-1.
REQ-038 With NUM_SRC=4 and all sources valid continuously -> grants rotate 0,1,2,3,0, and a 1-byte packet completes every 2 cycles.

Source files
------------

// File: rtl/axis_uart_pkg.sv
// Shared types for the AXI-stream to UART arbiter: FSM state encoding and idle-counter width.
package axis_uart_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_t;

  localparam int IDLE_CNT_W = 16;

  typedef logic [IDLE_CNT_W-1:0] idle_cnt_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first requester at or above ptr, wrapping around.
module rr_pick #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         found
);

  logic [W-1:0] idx;

  // Walk from the farthest offset down so the nearest requester is written last and wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = W'((int'(ptr) + i) % N);
      if (req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_uart_arbiter.sv
// Packet-locked round-robin arbiter merging NUM_SRC AXI-stream sources onto one UART TX stream.
//   state   | meaning
//   ST_IDLE | no packet owner; one arbitration cycle, no transfers
//   ST_LOCK | granted source owns the TX path until last beat or idle timeout
module axis_uart_arbiter
  import axis_uart_pkg::*;
#(
  parameter  int NUM_SRC   = 2,
  parameter  int DATA_BITS = 8,
  parameter  int TIMEOUT   = 255,
  localparam int GID_W     = $clog2(NUM_SRC)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SRC*DATA_BITS-1:0] s_axis_data,
  input  logic [NUM_SRC-1:0]           s_axis_valid,
  input  logic [NUM_SRC-1:0]           s_axis_last,
  output logic [NUM_SRC-1:0]           s_axis_ready,
  output logic [DATA_BITS-1:0]         m_axis_data,
  output logic                         m_axis_valid,
  output logic                         m_axis_last,
  input  logic                         m_axis_ready,
  output logic [GID_W-1:0]             grant_id,
  output logic                         busy,
  output logic                         timeout_pulse
);

  arb_state_t           state, state_nxt;
  idle_cnt_t            idle_cnt;
  logic [GID_W-1:0]     rr_ptr, rr_winner;
  logic                 rr_found;
  logic [DATA_BITS-1:0] src_data [NUM_SRC];

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) src_data[i] = s_axis_data[i*DATA_BITS +: DATA_BITS];
  end

  assign rr_ptr = (grant_id == GID_W'(NUM_SRC - 1)) ? '0 : grant_id + GID_W'(1);

  rr_pick #(.N(NUM_SRC), .W(GID_W)) u_rr_pick (
    .req    (s_axis_valid),
    .ptr    (rr_ptr),
    .winner (rr_winner),
    .found  (rr_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      grant_id <= GID_W'(NUM_SRC - 1);
      idle_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && rr_found) grant_id <= rr_winner;
      // Only a starved grant ages the counter; back-pressure holds it.
      if (state != ST_LOCK || (m_axis_valid && m_axis_ready) || timeout_pulse) idle_cnt <= '0;
      else if (!s_axis_valid[grant_id]) idle_cnt <= idle_cnt + IDLE_CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (rr_found) state_nxt = ST_LOCK;
      ST_LOCK: begin
        if ((m_axis_valid && m_axis_ready && m_axis_last) || timeout_pulse) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    m_axis_data   = '0;
    m_axis_valid  = 1'b0;
    m_axis_last   = 1'b0;
    s_axis_ready  = '0;
    busy          = (state == ST_LOCK);
    timeout_pulse = (state == ST_LOCK) && (idle_cnt == IDLE_CNT_W'(TIMEOUT));
    if (state == ST_LOCK) begin
      m_axis_data            = src_data[grant_id];
      m_axis_valid           = s_axis_valid[grant_id];
      m_axis_last            = s_axis_last[grant_id];
      s_axis_ready[grant_id] = m_axis_ready;
    end
  end

endmodule
